// File: rtl/uart_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// uart_transmitter_pkg
// Shared definitions for the UART transmitter and its baud tick generator.
// This file has no ports. It provides:
//   tx_state_t          FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   parity_mode_t       parity flavour, with PARITY_MODE fixed to even
//   OVERSAMPLE_DEFAULT  number of baud ticks per serial bit
//   BAUD_RATE           rate table indexed by the 3-bit baud_select code
//   baud_divider()      rounded clock divider for one baud tick
//   parity_bit()        parity of a data byte for a given mode
// ---------------------------------------------------------------------------
package uart_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic {
      PARITY_EVEN = 1'b0,
      PARITY_ODD  = 1'b1
   } parity_mode_t;

   localparam parity_mode_t PARITY_MODE = PARITY_EVEN;

   localparam int unsigned OVERSAMPLE_DEFAULT = 16;

   // Index 0 is code 3'b000 (300 baud), index 7 is code 3'b111 (115200 baud).
   localparam int unsigned BAUD_RATE [8] = '{300, 1200, 4800, 9600,
                                             19200, 38400, 57600, 115200};

   // Rounded to nearest: adding half the denominator before the integer divide.
   function automatic int unsigned baud_divider(int unsigned clk_hz,
                                                int unsigned oversample,
                                                logic [2:0]  sel);
      int unsigned ticks_per_sec;
      ticks_per_sec = oversample * BAUD_RATE[sel];
      return (clk_hz + ticks_per_sec / 2) / ticks_per_sec;
   endfunction

   // Even parity is the XOR of all data bits; odd parity inverts it.
   function automatic logic parity_bit(logic [7:0] data, parity_mode_t mode);
      return (^data) ^ (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_transmitter_baud.sv
// ---------------------------------------------------------------------------
// baud_controller
// Generates the oversampled baud tick for the UART transmitter.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   baud_select    3-bit rate code selecting the divider from the rate table
//   restart        pulls the divider back to zero so ticks align to a new frame
//   sample_ENABLE  one-cycle pulse per baud tick
// ---------------------------------------------------------------------------
module baud_controller
   import uart_transmitter_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       restart,
   output logic       sample_ENABLE
);

   // The slowest rate gives the largest divider, which sizes the counter.
   localparam int unsigned MAX_DIV = baud_divider(CLK_HZ, OVERSAMPLE, 3'd0);
   localparam int DIV_W = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

   // Terminal counts are elaboration-time constants, so hardware is only a mux.
   localparam logic [DIV_W-1:0] TERMINAL [8] = '{
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd0) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd1) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd2) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd3) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd4) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd5) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd6) - 1),
      DIV_W'(baud_divider(CLK_HZ, OVERSAMPLE, 3'd7) - 1)
   };

   logic [DIV_W-1:0] count;
   logic             at_terminal;

   assign at_terminal = (count == TERMINAL[baud_select]);

   // Restart suppresses the tick so a new frame always starts a full tick period.
   assign sample_ENABLE = at_terminal && !restart;

   // Divider counter: counts 0..divider-1, then wraps and emits a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (restart || at_terminal) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// 8E1 UART transmitter: start bit, 8 data bits LSB first, even parity, one
// stop bit. Each bit lasts OVERSAMPLE baud ticks from baud_controller.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset (aborts any frame)
//   Tx_DATA      byte to send, captured when a write is accepted
//   Tx_WR        one-cycle write strobe requesting a frame
//   Tx_EN        transmitter enable; gates new accepts only
//   baud_select  rate code, captured when a write is accepted
//   TxD          registered serial line, idle high
//   Tx_BUSY      high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Tx_DATA,
   input  logic       Tx_WR,
   input  logic       Tx_EN,
   input  logic [2:0] baud_select,
   output logic       TxD,
   output logic       Tx_BUSY
);

   localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);

   tx_state_t         state;
   tx_state_t         next_state;
   logic [7:0]        data_reg;
   logic [2:0]        baud_reg;
   logic [TICK_W-1:0] tick_cnt;
   logic [2:0]        bit_idx;
   logic              sample_enable;
   logic              accept;
   logic              bit_done;
   logic              line_bit;

   // Only IDLE accepts, so writes during a frame (including its last cycle) drop.
   assign accept   = Tx_WR && Tx_EN && (state == ST_IDLE);
   assign bit_done = sample_enable && (tick_cnt == LAST_TICK);

   // The divider runs from the latched rate so mid-frame baud_select changes
   // cannot stretch or shrink the current frame.
   baud_controller #(
      .CLK_HZ     (CLK_HZ),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud (
      .clk           (clk),
      .reset         (reset),
      .baud_select   (baud_reg),
      .restart       (accept),
      .sample_ENABLE (sample_enable)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: every non-idle state lasts one bit period, DATA lasts eight.
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:   if (accept)                      next_state = ST_START;
         ST_START:  if (bit_done)                    next_state = ST_DATA;
         ST_DATA:   if (bit_done && bit_idx == 3'd7) next_state = ST_PARITY;
         ST_PARITY: if (bit_done)                    next_state = ST_STOP;
         ST_STOP:   if (bit_done)                    next_state = ST_IDLE;
         default:                                    next_state = ST_IDLE;
      endcase
   end

   // Frame datapath: capture on accept, then count ticks within a bit and bits
   // within DATA. bit_idx only advances in DATA, so its 7->0 wrap coincides
   // with the DATA->PARITY transition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_reg <= '0;
         baud_reg <= '0;
         tick_cnt <= '0;
         bit_idx  <= '0;
      end else if (accept) begin
         data_reg <= Tx_DATA;
         baud_reg <= baud_select;
         tick_cnt <= '0;
         bit_idx  <= '0;
      end else if (state != ST_IDLE && sample_enable) begin
         tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
         if (bit_done && state == ST_DATA) begin
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // Bit value for the current state; registered below, hence one cycle late.
   always_comb begin
      line_bit = 1'b1;
      unique case (state)
         ST_IDLE:   line_bit = 1'b1;
         ST_START:  line_bit = 1'b0;
         ST_DATA:   line_bit = data_reg[bit_idx];
         ST_PARITY: line_bit = parity_bit(data_reg, PARITY_MODE);
         ST_STOP:   line_bit = 1'b1;
         default:   line_bit = 1'b1;
      endcase
   end

   // Output registers. Busy follows next_state so it rises right after the
   // accepting edge and drops on the edge that returns the FSM to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         TxD     <= 1'b1;
         Tx_BUSY <= 1'b0;
      end else begin
         TxD     <= line_bit;
         Tx_BUSY <= (next_state != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_uart_transmitter
// Directed self-checking bench for uart_transmitter at 50 MHz. Each frame is
// described by a hand-written 11-bit vector (bit 0 = start, bit 10 = stop)
// and the line and busy flag are compared every clock against it.
// ---------------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int BIT_FAST = 16 * 27;
   localparam int BIT_SLOW = 16 * 326;

   // Frame vectors {stop, parity, D7..D0, start}, parity worked out by hand.
   localparam logic [10:0] F_55 = 11'b1_0_01010101_0;
   localparam logic [10:0] F_80 = 11'b1_1_10000000_0;
   localparam logic [10:0] F_3A = 11'b1_0_00111010_0;
   localparam logic [10:0] F_A3 = 11'b1_0_10100011_0;
   localparam logic [10:0] F_3C = 11'b1_0_00111100_0;
   localparam logic [10:0] F_FF = 11'b1_0_11111111_0;

   logic       clk         = 1'b0;
   logic       reset       = 1'b1;
   logic [7:0] Tx_DATA     = 8'h00;
   logic       Tx_WR       = 1'b0;
   logic       Tx_EN       = 1'b1;
   logic [2:0] baud_select = 3'b111;
   logic       TxD;
   logic       Tx_BUSY;

   int passed = 0;
   int total  = 0;

   uart_transmitter #(
      .CLK_HZ     (50_000_000),
      .OVERSAMPLE (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Tx_DATA     (Tx_DATA),
      .Tx_WR       (Tx_WR),
      .Tx_EN       (Tx_EN),
      .baud_select (baud_select),
      .TxD         (TxD),
      .Tx_BUSY     (Tx_BUSY)
   );

   always #5 clk = ~clk;

   // Expected line n cycles after the accepting edge (sampled 1 ns after edge n).
   function automatic logic exp_line(logic [10:0] frame, int n, int bit_len);
      int k;
      if (n < 1) return 1'b1;
      k = (n - 1) / bit_len;
      if (k > 10) return 1'b1;
      return frame[k];
   endfunction

   function automatic logic exp_busy(int n, int bit_len);
      return (n < 11 * bit_len);
   endfunction

   // One-cycle write strobe; returns 1 ns after the accepting edge.
   task automatic applyStimulus(input logic [7:0] data, input logic [2:0] sel);
      @(negedge clk);
      Tx_DATA     = data;
      baud_select = sel;
      Tx_WR       = 1'b1;
      @(posedge clk);
      #1;
      Tx_WR = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (TxD !== 1'b1) $display("[TB] FAIL reset_txd: TxD=%b, required 1", TxD);
      else passed++;
      total++;
      if (Tx_BUSY !== 1'b0) $display("[TB] FAIL reset_busy: Tx_BUSY=%b, required 0", Tx_BUSY);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0)
         $display("[TB] FAIL post_reset_idle: TxD=%b Tx_BUSY=%b, required TxD=1 Tx_BUSY=0", TxD, Tx_BUSY);
      else passed++;
   endtask

   task automatic test_disabled();
      logic ok = 1'b1;
      Tx_EN = 1'b0;
      applyStimulus(8'hAA, 3'b111);
      for (int n = 0; n <= 600 && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         total++;
         if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            $display("[TB] FAIL disabled_write cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=1 Tx_BUSY=0", n, TxD, Tx_BUSY);
            ok = 1'b0;
         end else passed++;
      end
      Tx_EN = 1'b1;
   endtask

   task automatic test_frame_55();
      logic ok = 1'b1;
      int   busy_cycles = 0;
      applyStimulus(8'h55, 3'b111);
      for (int n = 0; n <= 11 * BIT_FAST + 4 && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         if (Tx_BUSY === 1'b1) busy_cycles++;
         total++;
         if (TxD !== exp_line(F_55, n, BIT_FAST) || Tx_BUSY !== exp_busy(n, BIT_FAST)) begin
            $display("[TB] FAIL frame_55 cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=%b Tx_BUSY=%b",
                     n, TxD, Tx_BUSY, exp_line(F_55, n, BIT_FAST), exp_busy(n, BIT_FAST));
            ok = 1'b0;
         end else passed++;
      end
      total++;
      if (busy_cycles != 4752) $display("[TB] FAIL busy_length_55: %0d clocks, required 4752", busy_cycles);
      else passed++;
   endtask

   // 0x80 frame with an ignored mid-frame write (and rate change), Tx_EN
   // dropped in D3, a write on the last STOP cycle that must be ignored, and
   // the same write still held on the first IDLE cycle, which must start 0x3A.
   task automatic test_back_to_back();
      logic ok = 1'b1;
      applyStimulus(8'h80, 3'b111);
      for (int n = 0; n <= 11 * BIT_FAST && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         total++;
         if (TxD !== exp_line(F_80, n, BIT_FAST) || Tx_BUSY !== exp_busy(n, BIT_FAST)) begin
            $display("[TB] FAIL frame_80 cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=%b Tx_BUSY=%b",
                     n, TxD, Tx_BUSY, exp_line(F_80, n, BIT_FAST), exp_busy(n, BIT_FAST));
            ok = 1'b0;
         end else passed++;
         if (n == 2 * BIT_FAST + 100) begin
            Tx_WR = 1'b1; Tx_DATA = 8'h00; baud_select = 3'b000;
         end
         if (n == 2 * BIT_FAST + 101) Tx_WR = 1'b0;
         if (n == 4 * BIT_FAST + 50)  Tx_EN = 1'b0;
         if (n == 10 * BIT_FAST + 50) Tx_EN = 1'b1;
         if (n == 11 * BIT_FAST - 1) begin
            Tx_WR = 1'b1; Tx_DATA = 8'h3A; baud_select = 3'b111;
         end
      end
      Tx_EN       = 1'b1;
      Tx_DATA     = 8'h3A;
      baud_select = 3'b111;
      Tx_WR       = 1'b1;
      @(posedge clk);
      #1;
      Tx_WR = 1'b0;
      ok = 1'b1;
      for (int n = 0; n <= 11 * BIT_FAST + 20 && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         total++;
         if (TxD !== exp_line(F_3A, n, BIT_FAST) || Tx_BUSY !== exp_busy(n, BIT_FAST)) begin
            $display("[TB] FAIL frame_3A cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=%b Tx_BUSY=%b",
                     n, TxD, Tx_BUSY, exp_line(F_3A, n, BIT_FAST), exp_busy(n, BIT_FAST));
            ok = 1'b0;
         end else passed++;
      end
   endtask

   task automatic test_reset_mid_frame();
      logic ok = 1'b1;
      applyStimulus(8'hA3, 3'b111);
      for (int n = 0; n <= 6 * BIT_FAST + 200 && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         total++;
         if (TxD !== exp_line(F_A3, n, BIT_FAST) || Tx_BUSY !== exp_busy(n, BIT_FAST)) begin
            $display("[TB] FAIL frame_A3 cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=%b Tx_BUSY=%b",
                     n, TxD, Tx_BUSY, exp_line(F_A3, n, BIT_FAST), exp_busy(n, BIT_FAST));
            ok = 1'b0;
         end else passed++;
      end
      reset = 1'b1;
      #1;
      total++;
      if (TxD !== 1'b1) $display("[TB] FAIL abort_txd: TxD=%b, required 1", TxD);
      else passed++;
      total++;
      if (Tx_BUSY !== 1'b0) $display("[TB] FAIL abort_busy: Tx_BUSY=%b, required 0", Tx_BUSY);
      else passed++;
      @(negedge clk);
      reset       = 1'b0;
      Tx_DATA     = 8'h3C;
      baud_select = 3'b111;
      Tx_WR       = 1'b1;
      @(posedge clk);
      #1;
      Tx_WR = 1'b0;
      ok = 1'b1;
      for (int n = 0; n <= 11 * BIT_FAST + 4 && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         total++;
         if (TxD !== exp_line(F_3C, n, BIT_FAST) || Tx_BUSY !== exp_busy(n, BIT_FAST)) begin
            $display("[TB] FAIL frame_3C cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=%b Tx_BUSY=%b",
                     n, TxD, Tx_BUSY, exp_line(F_3C, n, BIT_FAST), exp_busy(n, BIT_FAST));
            ok = 1'b0;
         end else passed++;
      end
   endtask

   task automatic test_slow_baud();
      logic ok = 1'b1;
      applyStimulus(8'hFF, 3'b011);
      for (int n = 0; n <= 11 * BIT_SLOW + 4 && ok; n++) begin
         if (n > 0) begin @(posedge clk); #1; end
         total++;
         if (TxD !== exp_line(F_FF, n, BIT_SLOW) || Tx_BUSY !== exp_busy(n, BIT_SLOW)) begin
            $display("[TB] FAIL frame_FF_9600 cycle %0d: TxD=%b Tx_BUSY=%b, required TxD=%b Tx_BUSY=%b",
                     n, TxD, Tx_BUSY, exp_line(F_FF, n, BIT_SLOW), exp_busy(n, BIT_SLOW));
            ok = 1'b0;
         end else passed++;
         if (n == 3 * BIT_SLOW + 100) begin
            baud_select = 3'b111;
            Tx_DATA     = 8'h00;
         end
      end
   endtask

   initial begin
      $display("[TB] uart_transmitter bench starting");
      test_reset();
      test_disabled();
      test_frame_55();
      test_back_to_back();
      test_reset_mid_frame();
      test_slow_baud();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, default 16, baud ticks per bit.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 Tx_DATA  input  8  byte to send, sampled on accept.
REQ-006 Tx_WR  input  1  write strobe; one-cycle pulse requests a frame.
REQ-007 Tx_EN  input  1  transmitter enable.
REQ-008 baud_select  input  3  rate code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
REQ-009 TxD  output  1  serial line, idle high, registered.
REQ-010 Tx_BUSY  output  1  high while a frame is in progress.

Function
REQ-011 Frame SHALL be: start bit 0, D0..D7 (LSB first), even parity bit (XOR of D7..D0), one stop bit 1, giving 11 bits.
REQ-012 Baud tick divider SHALL be round(CLK_HZ/(OVERSAMPLE*baud)), from a constant table indexed by baud_select; each bit SHALL last exactly OVERSAMPLE ticks.
REQ-013 Accept condition: Tx_WR=1 and Tx_EN=1 and state IDLE. On accept, Tx_DATA and baud_select SHALL be latched and the tick counter SHALL restart from zero.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE->START on accept; START->DATA after 16 ticks; DATA->PARITY after 8 bits; PARITY->STOP after 16 ticks; STOP->IDLE after 16 ticks.
REQ-016 TxD SHALL drive the new bit value on the cycle after the state/bit transition (one-cycle registered latency); in IDLE TxD SHALL be 1.
REQ-017 Tx_BUSY SHALL rise the cycle after accept and fall the cycle after STOP ends; a frame SHALL occupy 11*16*divider clocks.
REQ-018 Tx_WR while busy SHALL be ignored; no queueing.
REQ-019 Tx_EN deasserted mid-frame SHALL NOT abort the frame; it blocks only new accepts.
REQ-020 Changes to Tx_DATA or baud_select mid-frame SHALL have no effect on the current frame.
REQ-021 Tx_WR asserted in the same cycle the STOP state ends SHALL be ignored; acceptance resumes the next cycle in IDLE.
REQ-022 Bit index counter SHALL wrap 7->0 only on the DATA->PARITY transition.

Reset
REQ-023 On reset: state IDLE, TxD=1, Tx_BUSY=0, tick and bit counters 0, latched data 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; TxD returns to 1 asynchronously.
REQ-025 First accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-026 Shared package SHALL hold: FSM state encoding, baud_select rate table, OVERSAMPLE default, parity mode constant (even).
REQ-027 Sub-module baud_controller (inputs clk, reset, baud_select, restart; output sample_ENABLE, one-cycle pulse per tick) SHALL generate ticks; the FSM and shift logic reside in uart_transmitter.

Verification (CLK_HZ=50000000, baud_select=111, divider 27, bit = 432 clocks)
REQ-028 Send 0x55 -> TxD = 0,1,0,1,0,1,0,1,0, parity 0, stop 1; each bit held 432 clocks; Tx_BUSY high for 4752 clocks.
REQ-029 Send 0x80 -> data bits 0,0,0,0,0,0,0,1, parity 1; then a second Tx_WR 0x00 mid-frame -> ignored, line idle high after stop.
REQ-030 Tx_EN=0 with Tx_WR pulse -> TxD stays 1, Tx_BUSY stays 0; Tx_EN dropped during bit D3 -> frame completes unchanged.
REQ-031 Reset pulsed during D5 of 0xA3 -> TxD=1 and Tx_BUSY=0 immediately; a new Tx_WR 0x3C afterwards yields a complete correct frame.
REQ-032 baud_select=011 (9600, divider 326) send 0xFF -> bit 5216 clocks, parity 0; baud_select switched to 111 mid-frame -> bit length unchanged.
REQ-033 Back-to-back: Tx_WR on the first IDLE cycle after the frame ends -> accepted; no extra idle bit inserted beyond one clock.
